// File: rtl/common_pkg.sv
// Shared ALU op-code constants and arbiter FSM state type.
package common_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_SLR = 4'h0;
  localparam logic [3:0] OP_SLL = 4'h1;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_DEC = 4'h5;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_SLR, OP_SLL, OP_INC, OP_DEC, OP_ADD,
      OP_NOT, OP_AND, OP_OR, OP_MOV: op_legal = 1'b1;
      default:                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; pointer moves to the winner only on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = req;
    if (req[0] && req[1])
      grant = last ? 2'b01 : 2'b10;
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (accept)
      last <= grant[1];
  end

endmodule

// File: rtl/alu_arb.sv
// Shares one external ALU between two requesters: accept -> exec -> respond,
// one operation every three cycles, with a status flag register.
module alu_arb
  import common_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req_valid_in,
  output logic [NUM_PORTS-1:0]      req_ready_out,
  input  logic [NUM_PORTS-1:0][7:0] req_a_in,
  input  logic [NUM_PORTS-1:0][7:0] req_b_in,
  input  logic [NUM_PORTS-1:0][3:0] req_op_in,
  input  logic [NUM_PORTS-1:0]      req_flag_we_in,
  output logic [NUM_PORTS-1:0]      rsp_valid_out,
  output logic [7:0]                rsp_result_out,
  output logic [3:0]                rsp_status_out,
  output logic                      rsp_err_out,
  output logic [7:0]                alu_a_out,
  output logic [7:0]                alu_b_out,
  output logic [3:0]                alu_op_out,
  output logic [3:0]                alu_status_out,
  input  logic [7:0]                alu_result_in,
  input  logic [3:0]                alu_status_in,
  output logic [3:0]                flags_out
);

  state_t              state, state_nxt;
  logic [NUM_PORTS-1:0] grant;
  logic                accept;
  logic                sel;
  logic [7:0]          a_q, b_q;
  logic [3:0]          op_q;
  logic                we_q;
  logic                port_q;
  logic                legal;
  logic                exec;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid_in),
    .accept (accept),
    .grant  (grant)
  );

  // Gate with rst_n so ready stays low while reset is held.
  assign req_ready_out = (state == IDLE && rst_n) ? grant : '0;
  assign accept        = |req_ready_out;
  assign sel           = grant[1];
  assign exec          = (state == EXEC);
  assign legal         = op_legal(op_q);

  assign alu_a_out      = exec ? a_q     : '0;
  assign alu_b_out      = exec ? b_q     : '0;
  assign alu_op_out     = exec ? op_q    : '0;
  assign alu_status_out = exec ? flags_out : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_out = '0;
    if (state == RESP)
      rsp_valid_out[port_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      we_q           <= 1'b0;
      port_q         <= 1'b0;
      rsp_result_out <= '0;
      rsp_status_out <= '0;
      rsp_err_out    <= 1'b0;
      flags_out      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q    <= req_a_in[sel];
        b_q    <= req_b_in[sel];
        op_q   <= req_op_in[sel];
        we_q   <= req_flag_we_in[sel];
        port_q <= sel;
      end
      // Illegal ops never reach the flags and report the unchanged flags.
      if (exec) begin
        rsp_result_out <= legal ? alu_result_in : 8'h00;
        rsp_status_out <= legal ? alu_status_in : flags_out;
        rsp_err_out    <= !legal;
        if (legal && we_q)
          flags_out <= alu_status_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb with a behavioural ALU attached.
module tb_alu_arb;
  import common_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid_in = '0;
  logic [1:0]      req_ready_out;
  logic [1:0][7:0] req_a_in = '0;
  logic [1:0][7:0] req_b_in = '0;
  logic [1:0][3:0] req_op_in = '0;
  logic [1:0]      req_flag_we_in = '0;
  logic [1:0]      rsp_valid_out;
  logic [7:0]      rsp_result_out;
  logic [3:0]      rsp_status_out;
  logic            rsp_err_out;
  logic [7:0]      alu_a_out, alu_b_out;
  logic [3:0]      alu_op_out, alu_status_out;
  logic [7:0]      alu_result_in;
  logic [3:0]      alu_status_in;
  logic [3:0]      flags_out;

  always #5 clk = ~clk;

  alu_arb #(.NUM_PORTS(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_a_in       (req_a_in),
    .req_b_in       (req_b_in),
    .req_op_in      (req_op_in),
    .req_flag_we_in (req_flag_we_in),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_result_out (rsp_result_out),
    .rsp_status_out (rsp_status_out),
    .rsp_err_out    (rsp_err_out),
    .alu_a_out      (alu_a_out),
    .alu_b_out      (alu_b_out),
    .alu_op_out     (alu_op_out),
    .alu_status_out (alu_status_out),
    .alu_result_in  (alu_result_in),
    .alu_status_in  (alu_status_in),
    .flags_out      (flags_out)
  );

  // status = {zero, negative, carry, lsb}; illegal ops return junk.
  function automatic logic [11:0] alu_f(input logic [7:0] a, b, input logic [3:0] op);
    logic [8:0] r;
    case (op)
      OP_SLR:  r = {a[0], 1'b0, a[7:1]};
      OP_SLL:  r = {a, 1'b0};
      OP_INC:  r = {1'b0, a} + 9'd1;
      OP_DEC:  r = {1'b0, a} - 9'd1;
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_NOT:  r = {1'b0, ~a};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_MOV:  r = {1'b0, a};
      default: return {4'hF, 8'hAA};
    endcase
    return {r[7:0] == 8'h00, r[7], r[8], r[0], r[7:0]};
  endfunction

  function automatic logic legal_f(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  assign {alu_status_in, alu_result_in} = alu_f(alu_a_out, alu_b_out, alu_op_out);

  typedef struct {
    int         port;
    logic [7:0] res;
    logic [3:0] st;
    logic       err;
    logic [3:0] fl;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         gq[$];
  int         rcyc[$];
  logic [3:0] mflags = '0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid_out != 2'b00) begin
      if (sbq.size() == 0)
        chk("unexp_rsp", {30'd0, rsp_valid_out}, 32'd0);
      else begin
        e = sbq.pop_front();
        rcyc.push_back(cyc);
        chk("rsp_port",   {30'd0, rsp_valid_out}, 32'd1 << e.port);
        chk("rsp_result", {24'd0, rsp_result_out}, {24'd0, e.res});
        chk("rsp_status", {28'd0, rsp_status_out}, {28'd0, e.st});
        chk("rsp_err",    {31'd0, rsp_err_out}, {31'd0, e.err});
        chk("flags",      {28'd0, flags_out}, {28'd0, e.fl});
        chk("rsp_cycle",  cyc, e.cyc + 2);
        chk("alu_idle",   {8'd0, alu_a_out, alu_b_out, alu_op_out, alu_status_out}, 32'd0);
      end
    end
  end

  // Called at a negedge; holds valid until ready, then checks the EXEC drive.
  task automatic issue(input int p, input logic [7:0] a, b, input logic [3:0] op, input logic we);
    exp_t e;
    logic [3:0] fl_before;
    int n = 0;
    req_a_in[p] = a; req_b_in[p] = b; req_op_in[p] = op; req_flag_we_in[p] = we;
    req_valid_in[p] = 1'b1;
    forever begin
      #1;
      if (req_ready_out[p]) break;
      if (++n > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        req_valid_in[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    fl_before = mflags;
    e.port = p;
    e.cyc  = cyc;
    if (legal_f(op)) begin
      {e.st, e.res} = alu_f(a, b, op);
      e.err = 1'b0;
      if (we) mflags = e.st;
    end else begin
      e.res = 8'h00; e.st = mflags; e.err = 1'b1;
    end
    e.fl = mflags;
    sbq.push_back(e);
    gq.push_back(p);
    @(posedge clk);
    #1 req_valid_in[p] = 1'b0;
    @(negedge clk);
    chk("exec_a",  {24'd0, alu_a_out}, {24'd0, a});
    chk("exec_b",  {24'd0, alu_b_out}, {24'd0, b});
    chk("exec_op", {28'd0, alu_op_out}, {28'd0, op});
    chk("exec_st", {28'd0, alu_status_out}, {28'd0, fl_before});
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // Reset: ready must stay low even with requests pending.
    req_valid_in = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'd0, req_ready_out}, 32'd0);
    chk("rst_rsp",   {17'd0, rsp_valid_out, rsp_result_out, rsp_status_out, rsp_err_out}, 32'd0);
    chk("rst_alu",   {8'd0, alu_a_out, alu_b_out, alu_op_out, alu_status_out}, 32'd0);
    chk("rst_flags", {28'd0, flags_out}, 32'd0);
    req_valid_in = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Contention right after reset: port 0 first, then port 1, 3 cycles apart.
    gq.delete(); rcyc.delete();
    fork
      issue(0, 8'h11, 8'h00, OP_INC, 1'b0);
      issue(1, 8'h11, 8'hcf, OP_AND, 1'b0);
    join
    drain();
    chk("rr_first",  gq[0], 0);
    chk("rr_second", gq[1], 1);
    chk("rr_spacing", rcyc[1] - rcyc[0], 3);

    // ADD with flag write; OR without; illegal op with flag_we set.
    issue(0, 8'h11, 8'hcf, OP_ADD, 1'b1);
    drain();
    chk("add_flags", {28'd0, flags_out}, 32'h4);
    issue(1, 8'h11, 8'hcf, OP_OR, 1'b0);
    drain();
    chk("or_flags", {28'd0, flags_out}, 32'h4);
    issue(0, 8'h11, 8'hcf, 4'h3, 1'b1);
    drain();
    chk("ill_flags", {28'd0, flags_out}, 32'h4);

    // Port 0 granted last, so port 1 wins this contention.
    gq.delete(); rcyc.delete();
    fork
      issue(0, 8'h81, 8'h00, OP_SLR, 1'b0);
      issue(1, 8'h00, 8'h00, OP_DEC, 1'b1);
    join
    drain();
    chk("rr2_first",  gq[0], 1);
    chk("rr2_second", gq[1], 0);
    chk("rr2_spacing", rcyc[1] - rcyc[0], 3);

    // Reset during EXEC drops the operation entirely.
    req_a_in[0] = 8'h80; req_b_in[0] = 8'h80; req_op_in[0] = OP_ADD;
    req_flag_we_in[0] = 1'b1; req_valid_in[0] = 1'b1;
    #1 chk("rx_ready", {30'd0, req_ready_out}, 32'd1);
    @(posedge clk);
    #1 req_valid_in[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    mflags = '0;
    #1;
    chk("rx_flags", {28'd0, flags_out}, 32'd0);
    chk("rx_alu",   {28'd0, alu_op_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_norsp", {30'd0, rsp_valid_out}, 32'd0);
    end
    issue(1, 8'h00, 8'h00, OP_MOV, 1'b1);
    drain();
    chk("rx_after_flags", {28'd0, flags_out}, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
